// File: rtl/sum_pipe.sv
// sum_pipe: three-stage signed add / multiply / add datapath with clock enable.
// Stage 3 (equals) is built only when SUM_EQUALS_EN is defined; otherwise equals is 0.
module sum_pipe (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic signed [17:0] A,
  input  logic signed [12:0] B,
  input  logic signed [11:0] C,
  input  logic signed [14:0] D,
  input  logic signed [17:0] E,
  input  logic signed [18:0] F,
  output logic signed [18:0] sum_res,
  output logic signed [11:0] c_del,
  output logic signed [18:0] de_out,
  output logic signed [19:0] fe_out,
  output logic signed [30:0] Y,
  output logic signed [38:0] Y2,
  output logic signed [39:0] equals
);

  typedef struct packed {
    logic [18:0] ab;
    logic [18:0] de;
    logic [19:0] fe;
    logic [11:0] c;
  } s1_t;

  typedef struct packed {
    logic [30:0] y;
    logic [38:0] y2;
  } s2_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;

  // Operands are sign-extended to the result width before each
  // add/multiply, so the low bits are exact and nothing can overflow.
  always_comb begin
    s1_d    = '0;
    s1_d.ab = {A[17], A} + {{6{B[12]}}, B};
    s1_d.de = {{4{D[14]}}, D} + {E[17], E};
    s1_d.fe = {F[18], F} + {{2{E[17]}}, E};
    s1_d.c  = C;
  end

  always_comb begin
    s2_d    = '0;
    s2_d.y  = {{12{s1_q.ab[18]}}, s1_q.ab}
            * {{19{s1_q.c[11]}}, s1_q.c};
    s2_d.y2 = {{20{s1_q.de[18]}}, s1_q.de}
            * {{19{s1_q.fe[19]}}, s1_q.fe};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (ce) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

`ifdef SUM_EQUALS_EN
  logic [39:0] eq_d, eq_q;

  always_comb begin
    eq_d = {{9{s2_q.y[30]}}, s2_q.y}
         + {s2_q.y2[38], s2_q.y2};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eq_q <= '0;
    end else if (ce) begin
      eq_q <= eq_d;
    end
  end

  assign equals = eq_q;
`else
  assign equals = '0;
`endif

  assign sum_res = s1_q.ab;
  assign de_out  = s1_q.de;
  assign fe_out  = s1_q.fe;
  assign c_del   = s1_q.c;
  assign Y       = s2_q.y;
  assign Y2      = s2_q.y2;

endmodule

// File: tb/tb_sum_pipe.sv
// Self-checking bench for sum_pipe: fixed vectors, ce hold, async reset,
// and random traffic against a history-based arithmetic model.
module tb_sum_pipe;

  logic clk, rst, ce;
  logic signed [17:0] A;
  logic signed [12:0] B;
  logic signed [11:0] C;
  logic signed [14:0] D;
  logic signed [17:0] E;
  logic signed [18:0] F;
  logic signed [18:0] sum_res;
  logic signed [11:0] c_del;
  logic signed [18:0] de_out;
  logic signed [19:0] fe_out;
  logic signed [30:0] Y;
  logic signed [38:0] Y2;
  logic signed [39:0] equals;

  sum_pipe dut (
    .clk(clk), .rst(rst), .ce(ce),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F),
    .sum_res(sum_res), .c_del(c_del),
    .de_out(de_out), .fe_out(fe_out),
    .Y(Y), .Y2(Y2), .equals(equals)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint a, b, c, d, e, f;
  } vec_t;

  typedef struct {
    longint a, b, c, d, e, f;
    longint s, de, fe, cd, y, y2, eq;
  } tv_t;

  int total = 0;
  int passed = 0;

  // h[0] = inputs of last enabled edge, h[1] one before, h[2] two before
  vec_t h[3];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic longint prod1(vec_t v);
    return (v.a + v.b) * v.c;
  endfunction

  function automatic longint prod2(vec_t v);
    return (v.d + v.e) * (v.f + v.e);
  endfunction

  function automatic longint eq_of(vec_t v);
`ifdef SUM_EQUALS_EN
    return prod1(v) + prod2(v);
`else
    return 0;
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) h[i] = '{0, 0, 0, 0, 0, 0};
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".sum_res"}, longint'(sum_res), h[0].a + h[0].b);
    chk({tag, ".de_out"}, longint'(de_out), h[0].d + h[0].e);
    chk({tag, ".fe_out"}, longint'(fe_out), h[0].f + h[0].e);
    chk({tag, ".c_del"}, longint'(c_del), h[0].c);
    chk({tag, ".Y"}, longint'(Y), prod1(h[1]));
    chk({tag, ".Y2"}, longint'(Y2), prod2(h[1]));
    chk({tag, ".equals"}, longint'(equals), eq_of(h[2]));
  endtask

  task automatic drive(input vec_t v);
    A = 18'(v.a); B = 13'(v.b); C = 12'(v.c);
    D = 15'(v.d); E = 18'(v.e); F = 19'(v.f);
  endtask

  function automatic vec_t rnd();
    vec_t v;
    logic signed [17:0] ra, re;
    logic signed [12:0] rb;
    logic signed [11:0] rc;
    logic signed [14:0] rd;
    logic signed [18:0] rf;
    ra = 18'($urandom()); rb = 13'($urandom());
    rc = 12'($urandom()); rd = 15'($urandom());
    re = 18'($urandom()); rf = 19'($urandom());
    v = '{longint'(ra), longint'(rb), longint'(rc),
          longint'(rd), longint'(re), longint'(rf)};
    return v;
  endfunction

  // One clock edge; model advances only on an enabled, non-reset edge.
  task automatic tick(input logic ce_v);
    vec_t cur;
    ce = ce_v;
    cur = '{longint'(A), longint'(B), longint'(C),
            longint'(D), longint'(E), longint'(F)};
    @(posedge clk);
    if (ce_v && !rst) begin
      h[2] = h[1]; h[1] = h[0]; h[0] = cur;
    end
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_clear();
  endtask

  tv_t tv[3];
  vec_t nom, zero_v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tv[0] = '{435, 640, 256, 614, 614, 563,
              1075, 1228, 1177, 256, 275200, 1445356, 1720556};
    tv[1] = '{-1, -1, -3, -1, 0, 2,
              -2, -1, 2, -3, 6, -2, 4};
    tv[2] = '{-131072, -4096, -2048, -16384, -131072, -262144,
              -135168, -147456, -393216, -2048,
              276824064, 64'sd57982058496, 64'sd58258882560};
`ifndef SUM_EQUALS_EN
    for (int i = 0; i < 3; i++) tv[i].eq = 0;
`endif
    nom = '{435, 640, 256, 614, 614, 563};
    zero_v = '{0, 0, 0, 0, 0, 0};

    rst = 1'b1; ce = 1'b0;
    drive(nom);
    model_clear();
    #1;
    check_model("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fixed vectors: hold each for three enabled edges.
    for (int i = 0; i < 3; i++) begin
      vec_t v;
      v = '{tv[i].a, tv[i].b, tv[i].c, tv[i].d, tv[i].e, tv[i].f};
      drive(v);
      for (int k = 0; k < 3; k++) tick(1'b1);
      chk($sformatf("tv%0d.sum_res", i), longint'(sum_res), tv[i].s);
      chk($sformatf("tv%0d.de_out", i), longint'(de_out), tv[i].de);
      chk($sformatf("tv%0d.fe_out", i), longint'(fe_out), tv[i].fe);
      chk($sformatf("tv%0d.c_del", i), longint'(c_del), tv[i].cd);
      chk($sformatf("tv%0d.Y", i), longint'(Y), tv[i].y);
      chk($sformatf("tv%0d.Y2", i), longint'(Y2), tv[i].y2);
      chk($sformatf("tv%0d.equals", i), longint'(equals), tv[i].eq);
    end

    // ce hold: load nominal, freeze three cycles with other inputs.
    pulse_reset();
    drive(nom);
    tick(1'b1);
    check_model("load");
    for (int k = 0; k < 3; k++) begin
      drive(rnd());
      tick(1'b0);
      chk("hold.sum_res", longint'(sum_res), 1075);
      chk("hold.Y", longint'(Y), 0);
      check_model("hold");
    end
    drive(zero_v);
    tick(1'b1);
    chk("resume.Y", longint'(Y), 275200);
    chk("resume.Y2", longint'(Y2), 1445356);
    chk("resume.sum_res", longint'(sum_res), 0);
    tick(1'b1);
`ifdef SUM_EQUALS_EN
    chk("resume.equals", longint'(equals), 1720556);
`else
    chk("resume.equals", longint'(equals), 0);
`endif
    chk("resume.Y_drain", longint'(Y), 0);

    // Reset mid-stream: async assertion between edges.
    drive(nom);
    tick(1'b1);
    tick(1'b1);
    #3;
    rst = 1'b1;
    #1;
    model_clear();
    check_model("async_rst");
    tick(1'b1);
    check_model("rst_held");
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(nom);
      tick(1'b1);
      check_model("post_rst");
      if (k < 2) chk("post_rst.equals_zero", longint'(equals), 0);
    end

    // Random traffic with random ce.
    for (int n = 0; n < 300; n++) begin
      drive(rnd());
      tick(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      check_model("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
